stage_mem: RTL

//  Memory stage directly downstream of the execute stage. Owns the EX/MEM latch, the data-cache request FSM and the MEM/WB latch.

---
 rtl/stage_mem.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM latch, data-cache request FSM and MEM/WB latch.
// Optional LL/SC support is enabled by defining STAGE_MEM_ATOMIC_EN.
module stage_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RSEL_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluOut,
    input  logic [DATA_W-1:0] ex_rdat2,
    input  logic [RSEL_W-1:0] ex_regSel,
    input  logic              ex_regWrite,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              ex_memtoReg,
    input  logic              ex_jal,
    input  logic              ex_halt,
    input  logic              ex_datomic,
    input  logic [DATA_W-1:0] ex_npc,
    input  logic              flush,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              datomic,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_fwd_dat,
    output logic [RSEL_W-1:0] mem_fwd_regSel,
    output logic              mem_fwd_regWrite,
    output logic              wb_valid,
    output logic              wb_regWrite,
    output logic              wb_halt,
    output logic [RSEL_W-1:0] wb_regSel,
    output logic [DATA_W-1:0] wb_wdat
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdat2;
        logic [RSEL_W-1:0] regsel;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              jal;
        logic              halt;
        logic              datomic;
        logic [DATA_W-1:0] npc;
    } exm_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    exm_t              exm_q, exm_d, ex_in;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_halt_q, wb_halt_d;
    logic [RSEL_W-1:0] wb_regsel_q, wb_regsel_d;
    logic [DATA_W-1:0] wb_wdat_q, wb_wdat_d;

    logic              in_wait;
    logic              accept;
    logic              is_sc;
    logic              use_load;
    logic              regwrite_eff;
    logic              atomic_en;

`ifdef STAGE_MEM_ATOMIC_EN
    assign atomic_en = 1'b1;
`else
    assign atomic_en = 1'b0;
`endif

    // Decode of the latched op and stall/accept handshake
    always_comb begin
        in_wait      = (state_q == S_WAIT);
        mem_stall    = in_wait & ~dhit;
        accept       = (state_q != S_HALTED) & ~mem_stall;
        is_sc        = exm_q.memwrite & exm_q.datomic;
        // SC returns its success flag only when atomics exist; otherwise it is a plain store
        regwrite_eff = exm_q.regwrite & (atomic_en | ~is_sc);
        use_load     = exm_q.memtoreg | (atomic_en & is_sc);
    end

    // Incoming op; bubbles and flushed ops carry no controls or data
    always_comb begin
        ex_in = '0;
        if (ex_valid && !flush) begin
            ex_in.valid    = 1'b1;
            ex_in.alu      = ex_aluOut;
            ex_in.rdat2    = ex_rdat2;
            ex_in.regsel   = ex_regSel;
            ex_in.regwrite = ex_regWrite;
            ex_in.memread  = ex_memRead;
            ex_in.memwrite = ex_memWrite;
            ex_in.memtoreg = ex_memtoReg;
            ex_in.jal      = ex_jal;
            ex_in.halt     = ex_halt;
            ex_in.datomic  = ex_datomic;
            ex_in.npc      = ex_npc;
        end
    end

    // Next-state for the FSM and both pipeline latches
    always_comb begin
        state_d       = state_q;
        exm_d         = exm_q;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_regsel_d   = '0;
        wb_wdat_d     = '0;
        wb_halt_d     = wb_halt_q;

        if (state_q == S_HALTED) begin
            exm_d = '0;
        end else if (accept) begin
            exm_d = ex_in;
            if (exm_q.valid) begin
                wb_valid_d    = 1'b1;
                wb_regwrite_d = regwrite_eff;
                wb_regsel_d   = exm_q.regsel;
                wb_halt_d     = wb_halt_q | exm_q.halt;
                if (exm_q.jal) begin
                    wb_wdat_d = exm_q.npc;
                end else if (use_load) begin
                    wb_wdat_d = dmemload;
                end else begin
                    wb_wdat_d = exm_q.alu;
                end
            end
            if (exm_q.valid && exm_q.halt) begin
                state_d = S_HALTED;
            end else if (ex_in.memread || ex_in.memwrite) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            exm_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_halt_q     <= 1'b0;
            wb_regsel_q   <= '0;
            wb_wdat_q     <= '0;
        end else begin
            state_q       <= state_d;
            exm_q         <= exm_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_halt_q     <= wb_halt_d;
            wb_regsel_q   <= wb_regsel_d;
            wb_wdat_q     <= wb_wdat_d;
        end
    end

    // Cache request is held only while waiting; a write suppresses a read
    assign dmemWEN   = in_wait & exm_q.memwrite;
    assign dmemREN   = in_wait & exm_q.memread & ~exm_q.memwrite;
    assign datomic   = atomic_en & in_wait & exm_q.datomic;
    assign dmemaddr  = exm_q.alu;
    assign dmemstore = exm_q.rdat2;

    // Pending memory results are not forwardable; the hazard unit stalls instead
    assign mem_fwd_dat      = exm_q.jal ? exm_q.npc : exm_q.alu;
    assign mem_fwd_regSel   = exm_q.regsel;
    assign mem_fwd_regWrite = exm_q.valid & regwrite_eff & ~in_wait & (state_q != S_HALTED);

    assign wb_valid    = wb_valid_q;
    assign wb_regWrite = wb_regwrite_q;
    assign wb_halt     = wb_halt_q;
    assign wb_regSel   = wb_regsel_q;
    assign wb_wdat     = wb_wdat_q;

    a_rw_exclusive: assert property (@(posedge CLK) disable iff (RST)
        !(in_wait && exm_q.memread && exm_q.memwrite));

endmodule
